// File: rtl/adder_response_checker_if.sv
// Operand/response and result bundle between the stimulus side and the adder response checker.
interface adder_response_checker_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16
);
  logic                   start;
  logic                   stop;
  logic                   sample_valid;
  logic [WIDTH-1:0]       x_in;
  logic [WIDTH-1:0]       y_in;
  logic [WIDTH-1:0]       s_in;
  logic                   co_in;
  logic                   err_flag;
  logic [CNT_W-1:0]       err_count;
  logic [CNT_W-1:0]       sample_count;
  logic [3*WIDTH:0]       first_err;
  logic                   cov_full;
  logic                   busy;
  logic                   done;

  modport master (
    output start, stop, sample_valid, x_in, y_in, s_in, co_in,
    input  err_flag, err_count, sample_count, first_err, cov_full, busy, done
  );

  modport slave (
    input  start, stop, sample_valid, x_in, y_in, s_in, co_in,
    output err_flag, err_count, sample_count, first_err, cov_full, busy, done
  );
endinterface

// File: rtl/adder_response_checker.sv
// Response-side monitor for a ripple adder: recomputes X+Y, counts mismatches,
// captures the first failure and tracks operand-pair coverage per run.
module adder_response_checker #(
  parameter int WIDTH   = 4,
  parameter int LATENCY = 0,
  parameter int CNT_W   = 16
) (
  input logic                    clk,
  input logic                    rst_n,
  adder_response_checker_if.slave bus
);
  localparam int PAIRS = 2 ** (2 * WIDTH);
  localparam logic [2:0] DRAIN_LAST = 3'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           state_r;
  state_t           next_state_s;
  logic             run_entry_s;
  logic [2:0]       drain_cnt_r;
  logic             busy_r;
  logic             done_r;

  logic             cmp_valid_s;
  logic [WIDTH-1:0] cmp_x_s;
  logic [WIDTH-1:0] cmp_y_s;
  logic [WIDTH:0]   expected_s;
  logic [WIDTH:0]   response_s;
  logic             mismatch_s;

  logic             err_flag_r;
  logic [CNT_W-1:0] err_count_r;
  logic [CNT_W-1:0] sample_count_r;
  logic [3*WIDTH:0] first_err_r;
  logic             first_captured_r;
  logic [PAIRS-1:0] cov_map_r;
  logic             cov_full_r;

  // Next-state decode; start is only honoured from IDLE or DONE, stop wins in RUN.
  always_comb begin
    next_state_s = state_r;
    run_entry_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          next_state_s = ST_RUN;
          run_entry_s  = 1'b1;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (bus.stop) begin
          if (LATENCY > 0) begin
            next_state_s = ST_DRAIN;
          end else begin
            next_state_s = ST_DONE;
          end
        end else begin
          next_state_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_r == DRAIN_LAST) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        if (bus.start) begin
          next_state_s = ST_RUN;
          run_entry_s  = 1'b1;
        end else begin
          next_state_s = ST_DONE;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // State register with busy/done registered from the next state so they track it exactly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      busy_r  <= (next_state_s == ST_RUN) || (next_state_s == ST_DRAIN);
      done_r  <= (next_state_s == ST_DONE);
    end
  end

  // DRAIN dwell counter: restarts whenever the FSM is outside DRAIN.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drain_cnt_r <= 3'd0;
    end else if (state_r != ST_DRAIN) begin
      drain_cnt_r <= 3'd0;
    end else begin
      drain_cnt_r <= drain_cnt_r + 3'd1;
    end
  end

  generate
    if (LATENCY == 0) begin : g_comb
      // Combinational adder: the operands are compared in the cycle they are sampled.
      always_comb begin
        cmp_valid_s = (state_r == ST_RUN) && bus.sample_valid;
        cmp_x_s     = bus.x_in;
        cmp_y_s     = bus.y_in;
      end
    end else begin : g_line
      logic [LATENCY-1:0] vld_r;
      logic [WIDTH-1:0]   xs_r [LATENCY];
      logic [WIDTH-1:0]   ys_r [LATENCY];

      // Valid-tagged operand delay line aligning each pair with the adder's response.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          vld_r <= {LATENCY{1'b0}};
          for (int i = 0; i < LATENCY; i++) begin
            xs_r[i] <= {WIDTH{1'b0}};
            ys_r[i] <= {WIDTH{1'b0}};
          end
        end else begin
          vld_r[0] <= (state_r == ST_RUN) && bus.sample_valid;
          xs_r[0]  <= bus.x_in;
          ys_r[0]  <= bus.y_in;
          for (int i = 1; i < LATENCY; i++) begin
            vld_r[i] <= vld_r[i-1];
            xs_r[i]  <= xs_r[i-1];
            ys_r[i]  <= ys_r[i-1];
          end
        end
      end

      // Emerging slot is compared only while a run is active or draining.
      always_comb begin
        cmp_valid_s = vld_r[LATENCY-1] && ((state_r == ST_RUN) || (state_r == ST_DRAIN));
        cmp_x_s     = xs_r[LATENCY-1];
        cmp_y_s     = ys_r[LATENCY-1];
      end
    end
  endgenerate

  // Reference sum and comparison against the observed {Co,S}.
  always_comb begin
    expected_s = {1'b0, cmp_x_s} + {1'b0, cmp_y_s};
    response_s = {bus.co_in, bus.s_in};
    mismatch_s = cmp_valid_s && (response_s != expected_s);
  end

  // Run results: cleared on run entry, updated once per compare.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_flag_r       <= 1'b0;
      err_count_r      <= {CNT_W{1'b0}};
      sample_count_r   <= {CNT_W{1'b0}};
      first_err_r      <= {(3*WIDTH+1){1'b0}};
      first_captured_r <= 1'b0;
      cov_map_r        <= {PAIRS{1'b0}};
      cov_full_r       <= 1'b0;
    end else if (run_entry_s) begin
      err_flag_r       <= 1'b0;
      err_count_r      <= {CNT_W{1'b0}};
      sample_count_r   <= {CNT_W{1'b0}};
      first_err_r      <= {(3*WIDTH+1){1'b0}};
      first_captured_r <= 1'b0;
      cov_map_r        <= {PAIRS{1'b0}};
      cov_full_r       <= 1'b0;
    end else begin
      err_flag_r <= mismatch_s;
      if (cmp_valid_s) begin
        cov_map_r[{cmp_x_s, cmp_y_s}] <= 1'b1;
        if (sample_count_r != CNT_MAX) begin
          sample_count_r <= sample_count_r + CNT_W'(1);
        end else begin
          sample_count_r <= sample_count_r;
        end
      end else begin
        sample_count_r <= sample_count_r;
      end
      if (mismatch_s) begin
        if (err_count_r != CNT_MAX) begin
          err_count_r <= err_count_r + CNT_W'(1);
        end else begin
          err_count_r <= err_count_r;
        end
        if (!first_captured_r) begin
          first_err_r      <= {cmp_x_s, cmp_y_s, bus.s_in, bus.co_in};
          first_captured_r <= 1'b1;
        end else begin
          first_err_r      <= first_err_r;
        end
      end else begin
        err_count_r <= err_count_r;
      end
      // Sticky; sees the bitmap one edge after its final bit lands.
      cov_full_r <= cov_full_r | (&cov_map_r);
    end
  end

  assign bus.err_flag     = err_flag_r;
  assign bus.err_count    = err_count_r;
  assign bus.sample_count = sample_count_r;
  assign bus.first_err    = first_err_r;
  assign bus.cov_full     = cov_full_r;
  assign bus.busy         = busy_r;
  assign bus.done         = done_r;
endmodule

// File: tb/tb_adder_response_checker.sv
// Bench for adder_response_checker: three instances (LATENCY 0/2, CNT_W 16/2) share
// stimulus and are scored against a transaction-level reference model.
module tb_adder_response_checker;
  localparam int LAT  [3] = '{0, 2, 0};
  localparam int CMAX [3] = '{65535, 65535, 3};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, stop, sv;
  logic [3:0] x, y;
  logic [4:0] r0, r2;
  int errors = 0;
  int checks = 0;

  adder_response_checker_if #(.WIDTH(4), .CNT_W(16)) if0 ();
  adder_response_checker_if #(.WIDTH(4), .CNT_W(16)) if2 ();
  adder_response_checker_if #(.WIDTH(4), .CNT_W(2))  ifc ();

  assign if0.start = start; assign if0.stop = stop; assign if0.sample_valid = sv;
  assign if0.x_in = x; assign if0.y_in = y; assign if0.s_in = r0[3:0]; assign if0.co_in = r0[4];
  assign if2.start = start; assign if2.stop = stop; assign if2.sample_valid = sv;
  assign if2.x_in = x; assign if2.y_in = y; assign if2.s_in = r2[3:0]; assign if2.co_in = r2[4];
  assign ifc.start = start; assign ifc.stop = stop; assign ifc.sample_valid = sv;
  assign ifc.x_in = x; assign ifc.y_in = y; assign ifc.s_in = r0[3:0]; assign ifc.co_in = r0[4];

  adder_response_checker #(.WIDTH(4), .LATENCY(0), .CNT_W(16)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  adder_response_checker #(.WIDTH(4), .LATENCY(2), .CNT_W(16)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
  adder_response_checker #(.WIDTH(4), .LATENCY(0), .CNT_W(2))  dutc (.clk(clk), .rst_n(rst_n), .bus(ifc));

  logic        o_flag [3], o_cov [3], o_busy [3], o_done [3];
  logic [31:0] o_errc [3], o_samp [3];
  logic [12:0] o_first [3];
  assign o_flag[0] = if0.err_flag; assign o_flag[1] = if2.err_flag; assign o_flag[2] = ifc.err_flag;
  assign o_cov[0]  = if0.cov_full; assign o_cov[1]  = if2.cov_full; assign o_cov[2]  = ifc.cov_full;
  assign o_busy[0] = if0.busy;     assign o_busy[1] = if2.busy;     assign o_busy[2] = ifc.busy;
  assign o_done[0] = if0.done;     assign o_done[1] = if2.done;     assign o_done[2] = ifc.done;
  assign o_errc[0] = {16'd0, if0.err_count};    assign o_errc[1] = {16'd0, if2.err_count};
  assign o_errc[2] = {30'd0, ifc.err_count};
  assign o_samp[0] = {16'd0, if0.sample_count}; assign o_samp[1] = {16'd0, if2.sample_count};
  assign o_samp[2] = {30'd0, ifc.sample_count};
  assign o_first[0] = if0.first_err; assign o_first[1] = if2.first_err; assign o_first[2] = ifc.first_err;

  // Reference model: run phase (0 idle, 1 run, 2 drain, 3 done), results, and pending samples due at a cycle.
  typedef struct { int k; int due; logic [3:0] px; logic [3:0] py; } pend_t;
  pend_t pend[$];
  int    m_phase [3], m_drain [3], m_samp [3], m_errs [3], m_covcnt [3];
  bit    m_cov [3][256];
  bit    m_have [3], m_covfull [3], m_flag [3];
  logic [12:0] m_first [3];
  int    mc = 0;
  logic [3:0] hx [2], hy [2];

  function automatic logic [4:0] add(input logic [3:0] a, input logic [3:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  task automatic clear_model(input int k);
    m_samp[k] = 0; m_errs[k] = 0; m_covcnt[k] = 0; m_have[k] = 1'b0;
    m_covfull[k] = 1'b0; m_first[k] = 13'd0;
    for (int j = 0; j < 256; j++) m_cov[k][j] = 1'b0;
  endtask

  task automatic model_step();
    pend_t keep[$];
    pend_t e;
    logic [4:0] rs;
    int ph;
    bit act, allcov;
    for (int k = 0; k < 3; k++) begin
      rs = (k == 1) ? r2 : r0;
      ph = m_phase[k];
      act = rst_n && (ph == 1 || ph == 2);
      allcov = (m_covcnt[k] == 256);
      m_flag[k] = 1'b0;
      if (rst_n && ph == 1 && sv) begin
        e.k = k; e.due = mc + LAT[k]; e.px = x; e.py = y;
        pend.push_back(e);
      end
      keep.delete();
      foreach (pend[i]) begin
        if (pend[i].k != k) keep.push_back(pend[i]);
        else if (act && pend[i].due == mc) begin
          if (m_samp[k] < CMAX[k]) m_samp[k]++;
          if (!m_cov[k][{pend[i].px, pend[i].py}]) begin
            m_cov[k][{pend[i].px, pend[i].py}] = 1'b1;
            m_covcnt[k]++;
          end
          if (rs !== add(pend[i].px, pend[i].py)) begin
            m_flag[k] = 1'b1;
            if (m_errs[k] < CMAX[k]) m_errs[k]++;
            if (!m_have[k]) begin
              m_have[k] = 1'b1;
              m_first[k] = {pend[i].px, pend[i].py, rs[3:0], rs[4]};
            end
          end
        end else if (act) keep.push_back(pend[i]);
      end
      pend = keep;
      if (!rst_n) begin
        clear_model(k); m_phase[k] = 0; m_drain[k] = 0;
      end else if ((ph == 0 || ph == 3) && start) begin
        clear_model(k); m_phase[k] = 1;
      end else begin
        if (allcov) m_covfull[k] = 1'b1;
        if (ph == 1 && stop) begin
          if (LAT[k] > 0) begin m_phase[k] = 2; m_drain[k] = LAT[k]; end
          else m_phase[k] = 3;
        end else if (ph == 2) begin
          m_drain[k]--;
          if (m_drain[k] == 0) m_phase[k] = 3;
        end
      end
    end
    mc++;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    hx[1] = hx[0]; hy[1] = hy[0]; hx[0] = x; hy[0] = y;
  endtask

  task automatic drive(input bit v, input logic [3:0] xv, input logic [3:0] yv,
                       input logic [4:0] e0, input logic [4:0] e2);
    sv = v; x = xv; y = yv; r0 = e0; r2 = e2;
  endtask

  // Correct responses on both paths; the LATENCY=2 path answers the pair from two cycles ago.
  task automatic go(input bit v, input logic [3:0] xv, input logic [3:0] yv);
    drive(v, xv, yv, add(xv, yv), add(hx[1], hy[1]));
  endtask

  task automatic begin_run();
    start = 1'b1; go(1'b0, 4'd0, 4'd0); cycle(); start = 1'b0;
  endtask

  task automatic finish_run();
    stop = 1'b1; go(1'b0, 4'd0, 4'd0); cycle(); stop = 1'b0;
    repeat (3) begin go(1'b0, 4'($urandom), 4'($urandom)); cycle(); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    go(1'b0, 4'd0, 4'd0);
    repeat (3) cycle();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({o_flag[k], o_cov[k], o_busy[k], o_done[k], o_errc[k], o_samp[k], o_first[k]} !== 81'd0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d: flag=%b cov=%b busy=%b done=%b errc=%0d samp=%0d first=%h, want all 0",
                 k, o_flag[k], o_cov[k], o_busy[k], o_done[k], o_errc[k], o_samp[k], o_first[k]);
      end
    end
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_full_coverage();
    int unsigned mult;
    int i;
    logic [7:0] p;
    begin_run();
    mult = 2 * $urandom_range(0, 127) + 1;
    i = 0;
    while (i < 256) begin
      if ($urandom_range(0, 3) == 0) go(1'b0, 4'($urandom), 4'($urandom));
      else begin
        p = 8'(i * mult);
        go(1'b1, p[7:4], p[3:0]);
        i++;
      end
      cycle();
    end
    finish_run();
    checks++;
    if (o_samp[0] !== 32'd256) begin errors++; $display("FAIL cov_samples: got %0d want 256", o_samp[0]); end
    checks++;
    if (o_errc[0] !== 32'd0) begin errors++; $display("FAIL cov_errors: got %0d want 0", o_errc[0]); end
    checks++;
    if (o_cov[0] !== 1'b1 || o_done[0] !== 1'b1) begin
      errors++; $display("FAIL cov_full_done: cov=%b done=%b want 1 1", o_cov[0], o_done[0]);
    end
    for (int k = 1; k < 3; k++) begin
      checks++;
      if (o_samp[k] !== 32'(m_samp[k]) || o_cov[k] !== m_covfull[k] || o_done[k] !== 1'b1) begin
        errors++;
        $display("FAIL cov_model dut%0d: samp=%0d cov=%b done=%b want %0d %b 1",
                 k, o_samp[k], o_cov[k], o_done[k], m_samp[k], m_covfull[k]);
      end
    end
  endtask

  task automatic test_single_error();
    begin_run();
    drive(1'b1, 4'd2, 4'd1, 5'b0_0100, add(hx[1], hy[1]));
    cycle();
    checks++;
    if (o_flag[0] !== 1'b1) begin errors++; $display("FAIL err_pulse: got %b want 1", o_flag[0]); end
    checks++;
    if (o_errc[0] !== 32'd1) begin errors++; $display("FAIL err_count1: got %0d want 1", o_errc[0]); end
    checks++;
    if (o_first[0] !== {4'd2, 4'd1, 4'd4, 1'b0}) begin
      errors++; $display("FAIL first_err: got %h want %h", o_first[0], {4'd2, 4'd1, 4'd4, 1'b0});
    end
    go(1'b0, 4'd0, 4'd0);
    cycle();
    checks++;
    if (o_flag[0] !== 1'b0) begin errors++; $display("FAIL err_pulse_width: got %b want 0", o_flag[0]); end
    finish_run();
  endtask

  task automatic test_carry();
    begin_run();
    drive(1'b1, 4'd15, 4'd6, 5'b1_0101, add(hx[1], hy[1]));
    cycle();
    checks++;
    if (o_flag[0] !== 1'b0 || o_errc[0] !== 32'd0) begin
      errors++; $display("FAIL carry_ok: flag=%b errc=%0d want 0 0", o_flag[0], o_errc[0]);
    end
    drive(1'b1, 4'd15, 4'd6, 5'b0_0101, add(hx[1], hy[1]));
    cycle();
    checks++;
    if (o_flag[0] !== 1'b1 || o_errc[0] !== 32'd1) begin
      errors++; $display("FAIL carry_lost: flag=%b errc=%0d want 1 1", o_flag[0], o_errc[0]);
    end
    finish_run();
  endtask

  task automatic test_drain();
    logic [3:0] bx, by, rx, ry;
    logic [4:0] bad;
    begin_run();
    go(1'b1, 4'($urandom), 4'($urandom));
    cycle();
    bx = 4'($urandom); by = 4'($urandom);
    stop = 1'b1; go(1'b1, bx, by); cycle(); stop = 1'b0;
    checks++;
    if (o_busy[1] !== 1'b1 || o_done[1] !== 1'b0 || o_done[0] !== 1'b1) begin
      errors++; $display("FAIL drain_enter: busy2=%b done2=%b done0=%b want 1 0 1", o_busy[1], o_done[1], o_done[0]);
    end
    rx = 4'($urandom); ry = 4'($urandom);
    go(1'b1, rx, ry);
    cycle();
    checks++;
    if (o_busy[1] !== 1'b1 || o_flag[1] !== 1'b0) begin
      errors++; $display("FAIL drain_hold: busy=%b flag=%b want 1 0", o_busy[1], o_flag[1]);
    end
    bad = add(bx, by) ^ 5'd1;
    rx = 4'($urandom); ry = 4'($urandom);
    drive(1'b1, rx, ry, add(rx, ry), bad);
    cycle();
    checks++;
    if (o_busy[1] !== 1'b0 || o_done[1] !== 1'b1 || o_samp[1] !== 32'd2) begin
      errors++; $display("FAIL drain_done: busy=%b done=%b samp=%0d want 0 1 2", o_busy[1], o_done[1], o_samp[1]);
    end
    checks++;
    if (o_errc[1] !== 32'd1 || o_flag[1] !== 1'b1 || o_first[1] !== {bx, by, bad[3:0], bad[4]}) begin
      errors++; $display("FAIL drain_err: errc=%0d flag=%b first=%h want 1 1 %h",
                         o_errc[1], o_flag[1], o_first[1], {bx, by, bad[3:0], bad[4]});
    end
    repeat (2) begin go(1'b0, 4'd0, 4'd0); cycle(); end
  endtask

  task automatic test_saturation();
    logic [3:0] fx, fy, cx, cy;
    logic [4:0] fbad;
    begin_run();
    fx = 4'($urandom); fy = 4'($urandom); fbad = add(fx, fy) ^ 5'd3;
    for (int i = 0; i < 5; i++) begin
      cx = (i == 0) ? fx : 4'($urandom);
      cy = (i == 0) ? fy : 4'($urandom);
      drive(1'b1, cx, cy, add(cx, cy) ^ 5'd3, add(hx[1], hy[1]));
      cycle();
    end
    finish_run();
    checks++;
    if (o_errc[2] !== 32'd3 || o_samp[2] !== 32'd3) begin
      errors++; $display("FAIL sat_counts: errc=%0d samp=%0d want 3 3", o_errc[2], o_samp[2]);
    end
    checks++;
    if (o_first[2] !== {fx, fy, fbad[3:0], fbad[4]}) begin
      errors++; $display("FAIL sat_first: got %h want %h", o_first[2], {fx, fy, fbad[3:0], fbad[4]});
    end
    checks++;
    if (o_errc[0] !== 32'd5) begin errors++; $display("FAIL wide_count: got %0d want 5", o_errc[0]); end
  endtask

  task automatic test_reset_midrun();
    begin_run();
    repeat (3) begin drive(1'b1, 4'($urandom), 4'($urandom), 5'd31, 5'd31); cycle(); end
    rst_n = 1'b0; go(1'b0, 4'd0, 4'd0); cycle(); rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({o_flag[k], o_cov[k], o_busy[k], o_done[k], o_errc[k], o_samp[k], o_first[k]} !== 81'd0) begin
        errors++;
        $display("FAIL midrun_reset dut%0d: flag=%b busy=%b done=%b errc=%0d samp=%0d first=%h, want all 0",
                 k, o_flag[k], o_busy[k], o_done[k], o_errc[k], o_samp[k], o_first[k]);
      end
    end
    cycle();
    checks++;
    if (o_busy[1] !== 1'b0 || o_done[1] !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle: busy=%b done=%b want 0 0", o_busy[1], o_done[1]);
    end
    begin_run();
    start = 1'b1; stop = 1'b1; go(1'b0, 4'd0, 4'd0); cycle(); start = 1'b0; stop = 1'b0;
    checks++;
    if (o_busy[1] !== 1'b1 || o_done[1] !== 1'b0 || o_done[0] !== 1'b1) begin
      errors++; $display("FAIL start_stop: busy2=%b done2=%b done0=%b want 1 0 1", o_busy[1], o_done[1], o_done[0]);
    end
    repeat (3) cycle();
    checks++;
    if (o_done[1] !== 1'b1) begin errors++; $display("FAIL start_stop_done: got %b want 1", o_done[1]); end
  endtask

  task automatic test_random();
    logic [3:0] rx, ry;
    logic [4:0] e0, e2;
    for (int run = 0; run < 4; run++) begin
      begin_run();
      for (int n = 0; n < $urandom_range(20, 60); n++) begin
        rx = 4'($urandom); ry = 4'($urandom);
        e0 = add(rx, ry);
        e2 = add(hx[1], hy[1]);
        if ($urandom_range(0, 3) == 0) e0 = e0 ^ 5'($urandom_range(1, 31));
        if ($urandom_range(0, 3) == 0) e2 = e2 ^ 5'($urandom_range(1, 31));
        drive(1'($urandom_range(0, 1)), rx, ry, e0, e2);
        cycle();
        for (int k = 0; k < 3; k++) begin
          checks++;
          if (o_flag[k] !== m_flag[k]) begin
            errors++; $display("FAIL rand_flag dut%0d cyc%0d: got %b want %b", k, mc, o_flag[k], m_flag[k]);
          end
        end
      end
      finish_run();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (o_samp[k] !== 32'(m_samp[k]) || o_errc[k] !== 32'(m_errs[k]) || o_first[k] !== m_first[k] ||
            o_cov[k] !== m_covfull[k] || o_done[k] !== (m_phase[k] == 3)) begin
          errors++;
          $display("FAIL rand_run dut%0d: samp=%0d errc=%0d first=%h cov=%b done=%b want %0d %0d %h %b %b",
                   k, o_samp[k], o_errc[k], o_first[k], o_cov[k], o_done[k],
                   m_samp[k], m_errs[k], m_first[k], m_covfull[k], m_phase[k] == 3);
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    hx[0] = 4'd0; hx[1] = 4'd0; hy[0] = 4'd0; hy[1] = 4'd0;
    for (int k = 0; k < 3; k++) begin m_phase[k] = 0; m_drain[k] = 0; clear_model(k); m_flag[k] = 1'b0; end
    test_reset();
    test_full_coverage();
    test_single_error();
    test_carry();
    test_drain();
    test_saturation();
    test_reset_midrun();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
